// File: rtl/pc_gen_ras.sv
`default_nettype none
// ============================================================================
//  Module      : pc_gen_ras
//  Description : Fetch program-counter generator. Next-PC priority is
//                trap > redirect > stall > RAS return > sequential.
//                A small circular return-address stack predicts return targets.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_gen_ras #(
    parameter int                 XLEN         = 32,
    parameter logic [XLEN-1:0]    RESET_VECTOR = '0,
    parameter int                 RAS_DEPTH    = 4,
    parameter bit                 RVC_EN       = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_stall_n,
    input  logic                  i_rvc,
    input  logic                  i_trap,
    input  logic [XLEN-1:0]       i_trap_vector,
    input  logic                  i_redirect,
    input  logic [XLEN-1:0]       i_redirect_addr,
    input  logic                  i_ras_push,
    input  logic                  i_ras_pop,
    output logic [XLEN-1:0]       o_pc,
    output logic                  o_ras_empty,
    output logic                  o_ras_underflow,
    output logic                  o_misalign_err
);

    localparam int              c_PTR_W      = $clog2(RAS_DEPTH);
    localparam int              c_CNT_W      = c_PTR_W + 1;
    localparam logic [XLEN-1:0] c_ALIGN_MASK = RVC_EN ? XLEN'(1) : XLEN'(3);
    localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(RAS_DEPTH);

    logic [XLEN-1:0]    r_pc;
    logic [c_PTR_W-1:0] r_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_underflow;
    logic               r_misalign;
    logic [XLEN-1:0]    r_ras [RAS_DEPTH];

    logic [XLEN-1:0]    w_inc;
    logic [XLEN-1:0]    w_seq;
    logic [XLEN-1:0]    w_top;
    logic [XLEN-1:0]    w_target;
    logic               w_redir;
    logic               w_empty;
    logic               w_misalign;
    logic [XLEN-1:0]    w_pc_nxt;
    logic [c_PTR_W-1:0] w_ptr_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_wr_en;
    logic [c_PTR_W-1:0] w_wr_idx;
    logic               w_underflow;

    assign w_inc      = (RVC_EN && i_rvc) ? XLEN'(2) : XLEN'(4);
    assign w_seq      = r_pc + w_inc;
    assign w_top      = r_ras[r_ptr];
    assign w_empty    = (r_count == '0);
    assign w_redir    = i_trap | i_redirect;
    assign w_target   = i_trap ? i_trap_vector : i_redirect_addr;
    assign w_misalign = w_redir & (|(w_target & c_ALIGN_MASK));

    always_comb begin
        w_pc_nxt    = r_pc;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_count;
        w_wr_en     = 1'b0;
        w_wr_idx    = r_ptr;
        w_underflow = 1'b0;
        if (w_redir) begin
            // Misaligned targets still load, with the offending bits cleared.
            w_pc_nxt = w_target & ~c_ALIGN_MASK;
        end else if (i_stall_n) begin
            w_pc_nxt = w_seq;
            if (i_ras_push && i_ras_pop && !w_empty) begin
                // Co-routine swap: jump to the old top, replace it in place.
                w_pc_nxt = w_top;
                w_wr_en  = 1'b1;
                w_wr_idx = r_ptr;
            end else if (i_ras_push) begin
                // Also covers push+pop on an empty stack, which flags underflow.
                w_wr_en     = 1'b1;
                w_wr_idx    = r_ptr + 1'b1;
                w_ptr_nxt   = r_ptr + 1'b1;
                w_cnt_nxt   = (r_count == c_DEPTH) ? r_count : r_count + 1'b1;
                w_underflow = i_ras_pop;
            end else if (i_ras_pop) begin
                if (!w_empty) begin
                    w_pc_nxt  = w_top;
                    w_ptr_nxt = r_ptr - 1'b1;
                    w_cnt_nxt = r_count - 1'b1;
                end else begin
                    w_underflow = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_VECTOR;
            r_ptr       <= '0;
            r_count     <= '0;
            r_underflow <= 1'b0;
            r_misalign  <= 1'b0;
        end else begin
            r_pc        <= w_pc_nxt;
            r_ptr       <= w_ptr_nxt;
            r_count     <= w_cnt_nxt;
            r_underflow <= w_underflow;
            r_misalign  <= w_misalign;
        end
    end

    // Stack storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_ras[w_wr_idx] <= w_seq;
        end
    end

    assign o_pc            = r_pc;
    assign o_ras_empty     = w_empty;
    assign o_ras_underflow = r_underflow;
    assign o_misalign_err  = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen_ras.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_gen_ras
//  Description : Self-checking bench for pc_gen_ras against a queue-based model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_gen_ras;

    localparam logic [31:0] c_RV = 32'h8000_0000;

    logic        clk;
    logic        rst_n;
    logic        i_stall_n, i_rvc, i_trap, i_redirect, i_ras_push, i_ras_pop;
    logic [31:0] i_trap_vector, i_redirect_addr;
    logic [31:0] o_pc;
    logic        o_ras_empty, o_ras_underflow, o_misalign_err;

    int n_err = 0;
    int n_chk = 0;

    logic [31:0] m_pc;
    logic [31:0] m_q[$];
    logic        m_uf, m_mis;

    pc_gen_ras #(
        .XLEN        (32),
        .RESET_VECTOR(c_RV),
        .RAS_DEPTH   (4),
        .RVC_EN      (1'b1)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_stall_n      (i_stall_n),
        .i_rvc          (i_rvc),
        .i_trap         (i_trap),
        .i_trap_vector  (i_trap_vector),
        .i_redirect     (i_redirect),
        .i_redirect_addr(i_redirect_addr),
        .i_ras_push     (i_ras_push),
        .i_ras_pop      (i_ras_pop),
        .o_pc           (o_pc),
        .o_ras_empty    (o_ras_empty),
        .o_ras_underflow(o_ras_underflow),
        .o_misalign_err (o_misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs, advance the model, clock, and settle.
    task automatic drive(input logic s, input logic r, input logic t, input logic [31:0] tv,
                         input logic rd, input logic [31:0] ra, input logic pu, input logic po);
        logic [31:0] seq, tgt;
        i_stall_n = s; i_rvc = r; i_trap = t; i_trap_vector = tv;
        i_redirect = rd; i_redirect_addr = ra; i_ras_push = pu; i_ras_pop = po;
        seq   = m_pc + (r ? 32'd2 : 32'd4);
        m_uf  = 1'b0;
        m_mis = 1'b0;
        if (t || rd) begin
            tgt   = t ? tv : ra;
            m_mis = tgt[0];
            m_pc  = {tgt[31:1], 1'b0};
        end else if (s) begin
            if (pu && po && m_q.size() > 0) begin
                m_pc = m_q[m_q.size()-1];
                m_q[m_q.size()-1] = seq;
            end else if (pu) begin
                m_q.push_back(seq);
                if (m_q.size() > 4) void'(m_q.pop_front());
                m_uf = po;
                m_pc = seq;
            end else if (po && m_q.size() > 0) begin
                m_pc = m_q.pop_back();
            end else begin
                m_uf = po;
                m_pc = seq;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic r);
        drive(1'b1, r, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask
    task automatic redir(input logic [31:0] a);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, a, 1'b0, 1'b0);
    endtask
    task automatic push();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    endtask
    task automatic pop();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic model_reset();
        m_pc  = c_RV;
        m_q.delete();
        m_uf  = 1'b0;
        m_mis = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_stall_n = 1'b1; i_rvc = 1'b0; i_trap = 1'b0; i_redirect = 1'b0;
        i_trap_vector = '0; i_redirect_addr = '0; i_ras_push = 1'b0; i_ras_pop = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (o_pc !== c_RV) begin n_err++; $display("FAIL rst_pc got %h exp %h", o_pc, c_RV); end
        n_chk++; if (o_ras_empty !== 1'b1) begin n_err++; $display("FAIL rst_empty got %b exp 1", o_ras_empty); end
        n_chk++; if (o_ras_underflow !== 1'b0 || o_misalign_err !== 1'b0) begin
            n_err++; $display("FAIL rst_flags got uf=%b mis=%b exp 0 0", o_ras_underflow, o_misalign_err); end
        rst_n = 1'b1;
        step(1'b0);
        n_chk++; if (o_pc !== 32'h8000_0004) begin n_err++; $display("FAIL seq1 got %h exp 80000004", o_pc); end
        step(1'b0);
        n_chk++; if (o_pc !== 32'h8000_0008) begin n_err++; $display("FAIL seq2 got %h exp 80000008", o_pc); end
    endtask

    task automatic test_seq_rvc();
        redir(32'h0);
        n_chk++; if (o_pc !== 32'h0) begin n_err++; $display("FAIL redir0 got %h exp 0", o_pc); end
        step(1'b1);
        n_chk++; if (o_pc !== 32'h2) begin n_err++; $display("FAIL rvc_inc got %h exp 2", o_pc); end
        step(1'b0);
        n_chk++; if (o_pc !== 32'h6) begin n_err++; $display("FAIL rv_inc got %h exp 6", o_pc); end
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
            n_chk++; if (o_pc !== 32'h6) begin n_err++; $display("FAIL stall_hold got %h exp 6", o_pc); end
        end
        n_chk++; if (o_ras_empty !== 1'b1) begin n_err++; $display("FAIL stall_push got empty=%b exp 1", o_ras_empty); end
        redir(32'hFFFF_FFFC);
        step(1'b0);
        n_chk++; if (o_pc !== 32'h0) begin n_err++; $display("FAIL wrap got %h exp 0", o_pc); end
    endtask

    task automatic test_trap_redirect();
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0500, 1'b1, 32'h0000_0900, 1'b0, 1'b0);
        n_chk++; if (o_pc !== 32'h0000_0500) begin n_err++; $display("FAIL trap_prio got %h exp 500", o_pc); end
        n_chk++; if (o_misalign_err !== 1'b0) begin n_err++; $display("FAIL trap_mis got %b exp 0", o_misalign_err); end
        redir(32'h0000_1001);
        n_chk++; if (o_pc !== 32'h0000_1000) begin n_err++; $display("FAIL misalign_pc got %h exp 1000", o_pc); end
        n_chk++; if (o_misalign_err !== 1'b1) begin n_err++; $display("FAIL misalign_set got %b exp 1", o_misalign_err); end
        step(1'b0);
        n_chk++; if (o_misalign_err !== 1'b0) begin n_err++; $display("FAIL misalign_pulse got %b exp 0", o_misalign_err); end
    endtask

    task automatic test_ras_basic();
        redir(32'h100); push();
        redir(32'h200); push();
        pop();
        n_chk++; if (o_pc !== 32'h204) begin n_err++; $display("FAIL pop1 got %h exp 204", o_pc); end
        pop();
        n_chk++; if (o_pc !== 32'h104) begin n_err++; $display("FAIL pop2 got %h exp 104", o_pc); end
        n_chk++; if (o_ras_empty !== 1'b1) begin n_err++; $display("FAIL pop_empty got %b exp 1", o_ras_empty); end
        pop();
        n_chk++; if (o_ras_underflow !== 1'b1 || o_pc !== 32'h108) begin
            n_err++; $display("FAIL underflow got uf=%b pc=%h exp 1 108", o_ras_underflow, o_pc); end
        step(1'b0);
        n_chk++; if (o_ras_underflow !== 1'b0) begin n_err++; $display("FAIL uf_pulse got %b exp 0", o_ras_underflow); end
    endtask

    task automatic test_ras_depth();
        logic [31:0] exp_t [4] = '{32'h50, 32'h40, 32'h30, 32'h20};
        for (int k = 1; k <= 5; k++) begin
            redir(32'(k * 16 - 4));
            push();
        end
        for (int k = 0; k < 4; k++) begin
            pop();
            n_chk++; if (o_pc !== exp_t[k]) begin n_err++; $display("FAIL depth_pop%0d got %h exp %h", k, o_pc, exp_t[k]); end
        end
        pop();
        n_chk++; if (o_ras_underflow !== 1'b1) begin n_err++; $display("FAIL depth_uf got %b exp 1", o_ras_underflow); end
    endtask

    task automatic test_push_pop();
        redir(32'h2FC); push();
        redir(32'h400);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        n_chk++; if (o_pc !== 32'h300 || o_ras_empty !== 1'b0) begin
            n_err++; $display("FAIL coroutine got pc=%h empty=%b exp 300 0", o_pc, o_ras_empty); end
        pop();
        n_chk++; if (o_pc !== 32'h404 || o_ras_empty !== 1'b1) begin
            n_err++; $display("FAIL cor_top got pc=%h empty=%b exp 404 1", o_pc, o_ras_empty); end
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        n_chk++; if (o_ras_underflow !== 1'b1 || o_pc !== 32'h408 || o_ras_empty !== 1'b0) begin
            n_err++; $display("FAIL cor_empty got uf=%b pc=%h empty=%b exp 1 408 0", o_ras_underflow, o_pc, o_ras_empty); end
        push();
        rst_n = 1'b0;
        #1;
        n_chk++; if (o_pc !== c_RV || o_ras_empty !== 1'b1) begin
            n_err++; $display("FAIL async_rst got pc=%h empty=%b exp %h 1", o_pc, o_ras_empty, c_RV); end
        model_reset();
        #2 rst_n = 1'b1;
        step(1'b0);
        n_chk++; if (o_pc !== 32'h8000_0004) begin n_err++; $display("FAIL post_rst got %h exp 80000004", o_pc); end
    endtask

    task automatic test_random();
        logic [31:0] tv, ra;
        for (int k = 0; k < 400; k++) begin
            tv = $urandom;
            ra = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            drive($urandom_range(0, 7) != 0, 1'($urandom), $urandom_range(0, 15) == 0, tv,
                  $urandom_range(0, 7) == 0, ra, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            n_chk++; if (o_pc !== m_pc) begin n_err++; $display("FAIL rnd_pc[%0d] got %h exp %h", k, o_pc, m_pc); end
            n_chk++; if (o_ras_empty !== (m_q.size() == 0)) begin
                n_err++; $display("FAIL rnd_empty[%0d] got %b exp %b", k, o_ras_empty, m_q.size() == 0); end
            n_chk++; if (o_ras_underflow !== m_uf) begin
                n_err++; $display("FAIL rnd_uf[%0d] got %b exp %b", k, o_ras_underflow, m_uf); end
            n_chk++; if (o_misalign_err !== m_mis) begin
                n_err++; $display("FAIL rnd_mis[%0d] got %b exp %b", k, o_misalign_err, m_mis); end
        end
    endtask

    initial begin
        test_reset();
        test_seq_rvc();
        test_trap_redirect();
        test_ras_basic();
        test_ras_depth();
        test_push_pop();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
